// File: rtl/neuron_pkg.sv
// ---------------------------------------------------------------------------
// neuron_pkg
// Shared types and width helpers for the neuron family. The hidden-neuron,
// output-neuron and backprop blocks all use these.
//   neuron_state_e : pass sequencing states (IDLE/ACCUM/LOSS/DONE)
//   acc_w()        : signed accumulator width for N MACs of unsigned x by signed w
//   loss_w()       : unsigned width of the squared (acc - target) difference
// ---------------------------------------------------------------------------
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_LOSS  = 2'd2,
        ST_DONE  = 2'd3
    } neuron_state_e;

    // {1'b0,x} * w needs x_w+1+w_w-1+1 bits; summing n of them adds clog2(n).
    function automatic int acc_w(input int x_w, input int w_w, input int n);
        return x_w + w_w + 1 + $clog2(n);
    endfunction

    // diff is one bit wider than acc; squaring doubles the width.
    function automatic int loss_w(input int a_w);
        return 2 * (a_w + 1);
    endfunction

endpackage

// File: rtl/output_neuron_seq_if.sv
// ---------------------------------------------------------------------------
// output_neuron_seq_if
// Bundles the control, input-stream and result-stream signals of the
// sequential output neuron. Signal suffixes are from the neuron's viewpoint.
//   slave  : the neuron itself
//   master : the controller feeding pairs and consuming results
// ---------------------------------------------------------------------------
interface output_neuron_seq_if
    import neuron_pkg::*;
#(
    parameter int N_IN = 8,
    parameter int X_W  = 10,
    parameter int W_W  = 8,
    parameter int T_W  = 4
);
    localparam int ACC_W  = acc_w(X_W, W_W, N_IN);
    localparam int LOSS_W = loss_w(ACC_W);

    logic                       start_i;
    logic [T_W-1:0]             target_i;
    logic                       busy_o;
    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [X_W-1:0]             x_i;
    logic [W_W-1:0]             w_i;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [ACC_W-1:0]           final_o;
    logic [LOSS_W-1:0]          loss_o;
    logic                       zero_end_o;
    logic [N_IN*W_W-1:0]        weights_o;

    modport slave (
        input  start_i, target_i, in_valid_i, x_i, w_i, out_ready_i,
        output busy_o, in_ready_o, out_valid_o, final_o, loss_o, zero_end_o, weights_o
    );

    modport master (
        output start_i, target_i, in_valid_i, x_i, w_i, out_ready_i,
        input  busy_o, in_ready_o, out_valid_o, final_o, loss_o, zero_end_o, weights_o
    );

endinterface

// File: rtl/neuron_loss_sq.sv
// ---------------------------------------------------------------------------
// neuron_loss_sq
// Combinational (acc - target)^2. Also used by the backprop gradient path.
//   i_acc : signed accumulator value (ACC_W)
//   i_tgt : unsigned target, zero-extended (T_W)
//   o_sq  : unsigned square of the difference (LOSS_W), full precision
// ---------------------------------------------------------------------------
module neuron_loss_sq
    import neuron_pkg::*;
#(
    parameter int ACC_W = 22,
    parameter int T_W   = 4
)
(
    input  logic [ACC_W-1:0]           i_acc,
    input  logic [T_W-1:0]             i_tgt,
    output logic [loss_w(ACC_W)-1:0]   o_sq
);
    localparam int LOSS_W = loss_w(ACC_W);

    logic signed [ACC_W:0]    w_acc_ext;
    logic signed [ACC_W:0]    w_tgt_ext;
    logic signed [ACC_W:0]    w_diff;
    logic signed [LOSS_W-1:0] w_diff_wide;
    logic signed [LOSS_W-1:0] w_sq;

    assign w_acc_ext   = $signed({i_acc[ACC_W-1], i_acc});
    assign w_tgt_ext   = $signed({{(ACC_W+1-T_W){1'b0}}, i_tgt});
    assign w_diff      = w_acc_ext - w_tgt_ext;
    // Widen before multiplying so the product is evaluated at full width.
    assign w_diff_wide = LOSS_W'(w_diff);
    assign w_sq        = w_diff_wide * w_diff_wide;
    assign o_sq        = w_sq;

endmodule

// File: rtl/output_neuron_seq.sv
// ---------------------------------------------------------------------------
// output_neuron_seq
// Time-multiplexed output neuron: one signed MAC per accepted (x,w) pair over
// N_IN pairs using a single multiplier, then squared-error loss against the
// latched target. Results are held in DONE until the consumer accepts them.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : start/target/busy control, x/w input stream with
//                  in_valid/in_ready, result stream with out_valid/out_ready
//                  carrying final, loss, zero_end and the pass weights
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start_i
// ST_ACCUM | accepting N_IN (x,w) pairs, one MAC per handshake
// ST_LOSS  | one cycle: register final sum, zero flag and loss
// ST_DONE  | results valid; accept returns to IDLE, accept+start restarts
// ---------------------------------------------------------------------------
module output_neuron_seq
    import neuron_pkg::*;
#(
    parameter int N_IN = 8,
    parameter int X_W  = 10,
    parameter int W_W  = 8,
    parameter int T_W  = 4
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    output_neuron_seq_if.slave bus
);
    localparam int ACC_W  = acc_w(X_W, W_W, N_IN);
    localparam int LOSS_W = loss_w(ACC_W);
    localparam int CNT_W  = $clog2(N_IN);

    neuron_state_e            r_state;
    neuron_state_e            w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic [T_W-1:0]           r_tgt;
    logic [ACC_W-1:0]         r_final;
    logic [LOSS_W-1:0]        r_loss;
    logic                     r_zero_end;
    logic [N_IN*W_W-1:0]      r_weights;

    logic                     w_in_ready;
    logic                     w_hs;
    logic                     w_last;
    logic                     w_load;
    logic signed [ACC_W-1:0]  w_x_ext;
    logic signed [ACC_W-1:0]  w_w_ext;
    logic signed [ACC_W-1:0]  w_prod;
    logic                     w_zero;
    logic [LOSS_W-1:0]        w_sq;

    assign w_in_ready = (r_state == ST_ACCUM);
    assign w_hs       = bus.in_valid_i && w_in_ready;
    assign w_last     = (r_cnt == CNT_W'(N_IN - 1));

    // x is unsigned, so prefix a zero before treating it as signed.
    assign w_x_ext = ACC_W'($signed({1'b0, bus.x_i}));
    assign w_w_ext = ACC_W'($signed(bus.w_i));
    assign w_prod  = w_x_ext * w_w_ext;

    assign w_zero  = (r_acc == '0) && (r_tgt == '0);

    neuron_loss_sq #(
        .ACC_W (ACC_W),
        .T_W   (T_W)
    ) u_loss_sq (
        .i_acc (r_acc),
        .i_tgt (r_tgt),
        .o_sq  (w_sq)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    w_state_nxt = ST_ACCUM;
                    w_load      = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (w_hs && w_last) begin
                    w_state_nxt = ST_LOSS;
                end
            end
            ST_LOSS: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready_i) begin
                    if (bus.start_i) begin
                        w_state_nxt = ST_ACCUM;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_tgt      <= '0;
            r_final    <= '0;
            r_loss     <= '0;
            r_zero_end <= 1'b0;
            r_weights  <= '0;
        end else begin
            if (w_load) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_tgt <= bus.target_i;
            end else if (w_hs) begin
                r_acc                        <= r_acc + w_prod;
                r_cnt                        <= r_cnt + CNT_W'(1);
                r_weights[r_cnt*W_W +: W_W]  <= bus.w_i;
            end
            if (r_state == ST_LOSS) begin
                r_final    <= r_acc;
                r_zero_end <= w_zero;
                r_loss     <= w_zero ? '0 : w_sq;
            end
        end
    end

    assign bus.busy_o      = (r_state != ST_IDLE);
    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = (r_state == ST_DONE);
    assign bus.final_o     = r_final;
    assign bus.loss_o      = r_loss;
    assign bus.zero_end_o  = r_zero_end;
    assign bus.weights_o   = r_weights;

endmodule

// File: tb/tb_output_neuron_seq.sv
module tb_output_neuron_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    output_neuron_seq_if bus ();

    output_neuron_seq dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]         tgt;
        logic [79:0]        xs;
        logic [63:0]        ws;
        bit                 gaps;
        int                 hold;
        logic signed [21:0] e_final;
        logic [45:0]        e_loss;
        bit                 e_zero;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer dot product, then square of the difference.
    function automatic void model(inout vec_t v);
        longint s;
        longint d;
        s = 0;
        for (int k = 0; k < 8; k++) begin
            s += longint'(v.xs[k*10 +: 10]) * longint'($signed(v.ws[k*8 +: 8]));
        end
        d = s - longint'(v.tgt);
        v.e_final = 22'(s);
        v.e_zero  = (s == 0) && (v.tgt == 0);
        v.e_loss  = v.e_zero ? 46'd0 : 46'(d * d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] t);
        bus.start_i  = 1'b1;
        bus.target_i = t;
        tick();
        bus.start_i  = 1'b0;
        check("start_in_ready", 64'(bus.in_ready_o), 64'd1);
    endtask

    // Feed n pairs; optional random valid gaps and start_i noise.
    task automatic feed(input logic [79:0] xs, input logic [63:0] ws, input int n,
                        input bit gaps, input bit noise);
        bit hs;
        int budget;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    bus.in_valid_i = 1'b0;
                    bus.x_i        = 10'($urandom);
                    bus.w_i        = 8'($urandom);
                    if (noise) bus.start_i = 1'($urandom);
                    tick();
                end
            end
            bus.in_valid_i = 1'b1;
            bus.x_i        = xs[k*10 +: 10];
            bus.w_i        = ws[k*8 +: 8];
            budget = 0;
            hs     = 1'b0;
            while (!hs && budget < 20) begin
                if (noise) bus.start_i = 1'($urandom);
                @(negedge clk);
                hs = bus.in_ready_o;
                tick();
                budget++;
            end
            if (!hs) check("handshake_timeout", 64'd0, 64'd1);
        end
        bus.in_valid_i = 1'b0;
        bus.start_i    = 1'b0;
    endtask

    // Called one cycle after the last handshake edge: LOSS cycle.
    task automatic collect(input vec_t v, input bit b2b, input logic [3:0] next_t);
        logic [63:0] s_final, s_loss, s_zero, s_w;
        check("lat_loss_cycle_valid", 64'(bus.out_valid_o), 64'd0);
        tick();
        check("lat_done_valid", 64'(bus.out_valid_o), 64'd1);
        s_final = 64'(bus.final_o);
        s_loss  = 64'(bus.loss_o);
        s_zero  = 64'(bus.zero_end_o);
        s_w     = bus.weights_o;
        if (v.hold > 0) begin
            bus.out_ready_i = 1'b0;
            repeat (v.hold) begin
                bus.in_valid_i = 1'b1;
                tick();
            end
            bus.in_valid_i = 1'b0;
            check("hold_valid", 64'(bus.out_valid_o), 64'd1);
            check("hold_final", 64'(bus.final_o), s_final);
            check("hold_loss", 64'(bus.loss_o), s_loss);
            check("hold_zero", 64'(bus.zero_end_o), s_zero);
            check("hold_weights", bus.weights_o, s_w);
        end
        check("final", 64'($signed(bus.final_o)), 64'($signed(v.e_final)));
        check("loss", 64'(bus.loss_o), 64'(v.e_loss));
        check("zero_end", 64'(bus.zero_end_o), 64'(v.e_zero));
        check("weights", bus.weights_o, v.ws);
        bus.out_ready_i = 1'b1;
        if (b2b) begin
            bus.start_i  = 1'b1;
            bus.target_i = next_t;
        end
        tick();
        bus.out_ready_i = 1'b0;
        bus.start_i     = 1'b0;
        check("accept_valid_drop", 64'(bus.out_valid_o), 64'd0);
        if (b2b) check("b2b_in_ready", 64'(bus.in_ready_o), 64'd1);
        else     check("accept_idle", 64'(bus.busy_o), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        do_start(v.tgt);
        feed(v.xs, v.ws, 8, v.gaps, 1'b0);
        collect(v, 1'b0, 4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t b;
        bus.start_i     = 1'b0;
        bus.target_i    = '0;
        bus.in_valid_i  = 1'b0;
        bus.x_i         = '0;
        bus.w_i         = '0;
        bus.out_ready_i = 1'b0;

        vecs[0] = '{4'd4, {8{10'd2}}, {8{8'h40}}, 1'b0, 0, 22'sd1024, 46'd1040400, 1'b0};
        vecs[1] = '{4'd0, {8{10'd1}}, {8{8'h80}}, 1'b0, 0, 22'sh3FFC00, 46'd1048576, 1'b0};
        vecs[2] = '{4'd0, {8{10'd0}}, {8{8'h5A}}, 1'b0, 0, 22'sd0, 46'd0, 1'b1};
        vecs[3] = '{4'd3, {8{10'd0}}, {8{8'hA5}}, 1'b0, 0, 22'sd0, 46'd9, 1'b0};
        vecs[4] = '{4'd4, {8{10'd2}}, {8{8'h40}}, 1'b1, 5, 22'sd1024, 46'd1040400, 1'b0};
        vecs[5] = '{4'd15, {8{10'd1023}}, {8{8'h80}}, 1'b0, 1, 22'sd0, 46'd0, 1'b0};
        model(vecs[5]);
        for (int i = 6; i < 12; i++) begin
            vecs[i].tgt  = 4'($urandom);
            vecs[i].xs   = {$urandom, $urandom, 16'($urandom)};
            vecs[i].ws   = {$urandom, $urandom};
            vecs[i].gaps = 1'($urandom);
            vecs[i].hold = $urandom_range(0, 3);
            model(vecs[i]);
        end

        // Reset held two cycles.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_final", 64'(bus.final_o), 64'd0);
        check("rst_loss", 64'(bus.loss_o), 64'd0);
        check("rst_zero", 64'(bus.zero_end_o), 64'd0);
        check("rst_weights", bus.weights_o, 64'd0);

        // Reset mid-pass after three pairs.
        do_start(4'd9);
        feed({8{10'd1000}}, {8{8'h7F}}, 3, 1'b0, 1'b0);
        check("mid_busy", 64'(bus.busy_o), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 64'(bus.busy_o), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready_o), 64'd0);
        check("midrst_weights", bus.weights_o, 64'd0);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back: accept with start, new target 7, start noise in ACCUM.
        do_start(vecs[0].tgt);
        feed(vecs[0].xs, vecs[0].ws, 8, 1'b0, 1'b0);
        collect(vecs[0], 1'b1, 4'd7);
        check("b2b_busy", 64'(bus.busy_o), 64'd1);
        b = '{4'd7, {8{10'd2}}, {8{8'h40}}, 1'b0, 2, 22'sd1024, 46'd1034289, 1'b0};
        feed(b.xs, b.ws, 8, 1'b1, 1'b1);
        collect(b, 1'b0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
